// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HEADER_BYTES   = 2;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned COUNT_W        = 16;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_e;

    // States in which the stream handshake is open.
    function automatic logic accepts_bytes(input state_e s);
        return (s == HEADER) || (s == DATA);
    endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Byte-to-word shift register with a byte index; shared by header and data phases.
//   clk, reset       : clock, synchronous active-low reset
//   clear            : zero the word and the byte index (priority over load)
//   load             : shift byte_in into the low byte
//   last_idx         : index of the final byte of the current group
//   byte_in          : stream byte
//   word             : assembled word (first byte ends up most significant)
//   word_complete_c  : combinational, high when the final byte of a group is loaded
module byte_word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                load,
    input  logic [IDX_W-1:0]    last_idx,
    input  logic [BYTE_W-1:0]   byte_in,
    output logic [WORD_W-1:0]   word,
    output logic                word_complete_c
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;

    assign word_complete_c = load && (idx_q == last_idx);
    assign word            = word_q;

    // Shift in a byte; the index wraps to zero after the last byte of a group.
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (load) begin
            word_d = {word_q[WORD_W-BYTE_W-1:0], byte_in};
            idx_d  = word_complete_c ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time loader: receives a word-count header and instruction bytes over a
// valid/ready stream and writes assembled words to program memory, holding the
// CPU in reset until the load finishes.
//   clk, reset    : clock, synchronous active-low reset
//   Start         : begin a load from IDLE, DONE or ERROR
//   ByteIn/ByteValid/ByteReady : byte stream handshake
//   MemWrite/MemAddress/MemData : one-cycle program memory write port
//   CpuHold       : CPU reset request (low only in DONE)
//   Busy/Done/Error : status decodes
//   WordsWritten  : words written during the current load
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteIn,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] MemAddress,
    output logic [DATA_WIDTH-1:0] MemData,
    output logic                  CpuHold,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic [15:0]           WordsWritten
);

    localparam logic [COUNT_W-1:0] MAX_WORDS = COUNT_W'(MEMORY_DEPTH);
    localparam logic [IDX_W-1:0]   HDR_LAST  = IDX_W'(HEADER_BYTES - 1);
    localparam logic [IDX_W-1:0]   WORD_LAST = IDX_W'(BYTES_PER_WORD - 1);

    state_e                 state_q, state_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic [COUNT_W-1:0]     words_q, words_d;
    logic [DATA_WIDTH-1:0]  addr_q,  addr_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   mem_write_q,  mem_write_d;
    logic                   cpu_hold_q,   cpu_hold_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    logic                   error_q,      error_d;

    logic                   accept_c;
    logic                   asm_clear_c;
    logic                   asm_complete_c;
    logic [IDX_W-1:0]       asm_last_c;
    logic [DATA_WIDTH-1:0]  asm_word;
    logic [COUNT_W-1:0]     count_next_c;
    logic [COUNT_W-1:0]     words_inc_c;

    assign accept_c     = ByteValid && byte_ready_q;
    assign asm_last_c   = (state_q == HEADER) ? HDR_LAST : WORD_LAST;
    // The header high byte already sits in the assembler's low byte.
    assign count_next_c = {asm_word[BYTE_W-1:0], ByteIn};
    assign words_inc_c  = words_q + COUNT_W'(1);

    byte_word_assembler #(
        .WORD_W (DATA_WIDTH)
    ) u_asm (
        .clk             (clk),
        .reset           (reset),
        .clear           (asm_clear_c),
        .load            (accept_c),
        .last_idx        (asm_last_c),
        .byte_in         (ByteIn),
        .word            (asm_word),
        .word_complete_c (asm_complete_c)
    );

    // Next state, counters and registered output decodes.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        words_d     = words_q;
        asm_clear_c = 1'b0;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (Start) begin
                    state_d     = HEADER;
                    count_d     = '0;
                    words_d     = '0;
                    asm_clear_c = 1'b1;
                end
            end
            HEADER: begin
                if (asm_complete_c) begin
                    count_d = count_next_c;
                    if (count_next_c == '0) begin
                        state_d = DONE;
                    end else if (count_next_c > MAX_WORDS) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (asm_complete_c) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_inc_c;
                state_d = (words_inc_c == count_q) ? DONE : DATA;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Address tracks the word counter so it is already valid in WRITE.
        addr_d       = BASE_ADDRESS + (DATA_WIDTH'(words_d) << 2);
        byte_ready_d = accepts_bytes(state_d);
        mem_write_d  = (state_d == WRITE);
        cpu_hold_d   = (state_d != DONE);
        busy_d       = (state_d == HEADER) || (state_d == DATA) || (state_d == WRITE);
        done_d       = (state_d == DONE);
        error_d      = (state_d == ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            words_q      <= '0;
            addr_q       <= BASE_ADDRESS;
            byte_ready_q <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_hold_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            words_q      <= words_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            mem_write_q  <= mem_write_d;
            cpu_hold_q   <= cpu_hold_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign ByteReady    = byte_ready_q;
    assign MemWrite     = mem_write_q;
    assign MemAddress   = addr_q;
    assign MemData      = asm_word;
    assign CpuHold      = cpu_hold_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;
    assign WordsWritten = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemData;
    logic        CpuHold;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [15:0] WordsWritten;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } obs_t;

    exp_t        exp_q[$];
    obs_t        obs_q[$];
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned start_cyc;

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .Start        (Start),
        .ByteIn       (ByteIn),
        .ByteValid    (ByteValid),
        .ByteReady    (ByteReady),
        .MemWrite     (MemWrite),
        .MemAddress   (MemAddress),
        .MemData      (MemData),
        .CpuHold      (CpuHold),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error),
        .WordsWritten (WordsWritten)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe with its cycle stamp.
    always @(negedge clk) begin
        obs_t o;
        if (MemWrite === 1'b1) begin
            o = {MemAddress, MemData, cyc};
            obs_q.push_back(o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Present a byte at a falling edge; it transfers at the next rising edge with ByteReady high.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        ByteIn    = b;
        ByteValid = 1'b1;
        while (ByteReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("byte_timeout", 32'(ByteReady), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int unsigned idx);
        exp_t e;
        e = {BASE + 32'(idx * 4), w};
        exp_q.push_back(e);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (Done !== 1'b1 && Error !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 32'(Done), 32'd1);
    endtask

    // Pop expected writes against observed writes.
    task automatic check_writes(input string tag);
        exp_t e;
        obs_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, 32'(obs_q.size()), 32'd1);
            end else begin
                o = obs_q.pop_front();
                chk({tag, "_addr"}, o.addr, e.addr);
                chk({tag, "_data"}, o.data, e.data);
            end
        end
        chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    endtask

    task automatic check_timing(input string tag, input int unsigned first_rel);
        chk({tag, "_nwr"}, 32'(obs_q.size()), 32'd2);
        if (obs_q.size() >= 2) begin
            chk({tag, "_lat"}, obs_q[0].cyc - start_cyc, 32'(first_rel));
            chk({tag, "_gap"}, obs_q[1].cyc - obs_q[0].cyc, 32'd5);
        end
    endtask

    task automatic send_two_words(input int unsigned stall);
        exp_t e;
        e = {BASE, 32'h2008_0005};
        exp_q.push_back(e);
        e = {BASE + 32'd4, 32'h3C01_1001};
        exp_q.push_back(e);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08);
        if (stall > 0) begin
            ByteValid = 1'b0;
            tick(stall);
        end
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h3C); send_byte(8'h01);
        send_byte(8'h10); send_byte(8'h01);
        ByteValid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        reset     = 1'b0;
        Start     = 1'b0;
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        tick(3);

        // Reset values
        chk("rst_ready", 32'(ByteReady), 32'd0);
        chk("rst_wr",    32'(MemWrite), 32'd0);
        chk("rst_addr",  MemAddress, BASE);
        chk("rst_data",  MemData, 32'd0);
        chk("rst_hold",  32'(CpuHold), 32'd1);
        chk("rst_busy",  32'(Busy), 32'd0);
        chk("rst_done",  32'(Done), 32'd0);
        chk("rst_err",   32'(Error), 32'd0);
        chk("rst_words", 32'(WordsWritten), 32'd0);
        reset = 1'b1;
        tick(2);

        // Two-word load, continuous valid
        pulse_start();
        start_cyc = cyc;
        chk("t2_busy", 32'(Busy), 32'd1);
        send_two_words(0);
        wait_done("t2");
        check_timing("t2", 6);
        check_writes("t2");
        chk("t2_hold",  32'(CpuHold), 32'd0);
        chk("t2_words", 32'(WordsWritten), 32'd2);

        // Same stream with a 7-cycle gap after the second data byte
        pulse_start();
        start_cyc = cyc;
        send_two_words(7);
        wait_done("t3");
        check_timing("t3", 13);
        check_writes("t3");
        chk("t3_words", 32'(WordsWritten), 32'd2);

        // Oversized header
        pulse_start();
        send_byte(8'h00); send_byte(8'h21);
        ByteValid = 1'b0;
        chk("t4_err",   32'(Error), 32'd1);
        chk("t4_ready", 32'(ByteReady), 32'd0);
        chk("t4_hold",  32'(CpuHold), 32'd1);
        tick(5);
        chk("t4_nowr",  32'(obs_q.size()), 32'd0);

        // Recovery load of one word
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h1234_5678, 0);
        ByteValid = 1'b0;
        wait_done("t4b");
        check_writes("t4b");
        chk("t4b_err",   32'(Error), 32'd0);
        chk("t4b_words", 32'(WordsWritten), 32'd1);

        // Zero-length load
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        ByteValid = 1'b0;
        chk("t5_done",  32'(Done), 32'd1);
        chk("t5_words", 32'(WordsWritten), 32'd0);
        tick(3);
        chk("t5_nowr",  32'(obs_q.size()), 32'd0);

        // Reset in the middle of a data word
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08);
        reset = 1'b0;
        tick(3);
        chk("t6_ready", 32'(ByteReady), 32'd0);
        chk("t6_data",  MemData, 32'd0);
        chk("t6_addr",  MemAddress, BASE);
        chk("t6_busy",  32'(Busy), 32'd0);
        chk("t6_hold",  32'(CpuHold), 32'd1);
        reset = 1'b1;
        tick(10);
        ByteValid = 1'b0;
        chk("t6_nowr",  32'(obs_q.size()), 32'd0);
        chk("t6_done",  32'(Done), 32'd0);
        chk("t6_err",   32'(Error), 32'd0);
        chk("t6_idle",  32'(ByteReady), 32'd0);

        // Full-depth load with a stray Start pulse mid-stream
        pulse_start();
        send_byte(8'h00); send_byte(8'h20);
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            send_word(w, i);
            if (i == 10) begin
                ByteValid = 1'b0;
                pulse_start();
                chk("t7_stillbusy", 32'(Busy), 32'd1);
            end
        end
        ByteValid = 1'b0;
        wait_done("t7");
        if (obs_q.size() > 0)
            chk("t7_last", obs_q[obs_q.size()-1].addr, 32'h0040_007C);
        else
            chk("t7_nowr", 32'(obs_q.size()), 32'd32);
        check_writes("t7");
        chk("t7_words", 32'(WordsWritten), 32'd32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time writer for the instruction memory that the single-cycle MIPS fetches from.
- Receives a byte stream over a valid/ready handshake: a 16-bit word-count header, then instruction bytes, most significant byte first.
- Assembles each group of four bytes into a 32-bit word and writes it through a one-cycle write port at sequential byte addresses.
- Holds the CPU in reset until loading completes.

Parameters:
- MEMORY_DEPTH, 32: number of 32-bit words in the target program memory; the maximum accepted word count.
- DATA_WIDTH, 32: instruction word width and address width.
- BASE_ADDRESS, 32'h0040_0000: byte address of the first word written.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- Start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- ByteIn  in  8  stream byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts ByteIn this cycle.
- MemWrite  out  1  write strobe to program memory, one cycle per word.
- MemAddress  out  DATA_WIDTH  byte address of the word being written (word-aligned).
- MemData  out  DATA_WIDTH  assembled instruction word.
- CpuHold  out  1  high while IDLE/HEADER/DATA/WRITE/ERROR; CPU kept in reset.
- Busy  out  1  high in HEADER, DATA, WRITE.
- Done  out  1  high in DONE.
- Error  out  1  high in ERROR.
- WordsWritten  out  16  count of words written in the current load.

Behaviour:
- Reset (reset==0 at a clk edge) forces state IDLE and clears all registers.
  - Reset values: ByteReady=0, MemWrite=0, MemAddress=BASE_ADDRESS, MemData=0, CpuHold=1, Busy=0, Done=0, Error=0, WordsWritten=0.
  - Reset mid-load abandons the load immediately; no further MemWrite is issued.
- Handshake: a byte transfers on a rising edge where ByteValid && ByteReady. ByteReady is a registered state decode, high only in HEADER and DATA.
- States:
  - IDLE: Start -> HEADER; clear WordsWritten, byte index and header register.
  - HEADER: accept 2 bytes, high byte first, into Count[15:0]. On the 2nd byte:
    - Count==0 -> DONE.
    - Count>MEMORY_DEPTH -> ERROR.
    - otherwise -> DATA.
  - DATA: accept 4 bytes, shifting left into MemData (first byte lands in [31:24]). On the 4th byte -> WRITE.
  - WRITE: lasts exactly one cycle.
    - MemWrite=1; MemAddress=BASE_ADDRESS+4*WordsWritten; MemData stable; ByteReady=0.
    - On exit WordsWritten increments. If the new value equals Count -> DONE, else -> DATA.
  - DONE: Done=1, CpuHold=0; ignores stream bytes. Start -> HEADER (reload).
  - ERROR: Error=1, CpuHold=1, no writes. Start -> HEADER.
- Start asserted in HEADER, DATA or WRITE is ignored.
- Latency: MemWrite is asserted on the cycle after the 4th byte of a word is accepted. Maximum throughput is one word per 5 cycles.
- Gaps in ByteValid stall without a timeout; partial words are retained across stalls.
- MemAddress arithmetic is DATA_WIDTH-bit unsigned; the Count<=MEMORY_DEPTH check guarantees no wrap beyond the memory.
- Count==MEMORY_DEPTH is legal; the last write goes to BASE_ADDRESS+4*(MEMORY_DEPTH-1).

Decomposition:
- Shared package `loader_pkg`:
  - state enum (IDLE, HEADER, DATA, WRITE, DONE, ERROR);
  - BYTES_PER_WORD=4;
  - HEADER_BYTES=2.
- One natural sub-module, `byte_word_assembler`: byte shift register plus 2-bit index, with load/clear and word_complete output. It is reused for the header (2 bytes) and data (4 bytes).
- The FSM, address counter and word counter stay in the top module.

Test Plan:
- Reset held low 3 cycles during a DATA transfer -> MemWrite never asserts; all outputs at reset values; state IDLE; CpuHold=1.
- Start; header 00 02; bytes 20 08 00 05 3C 01 10 01 with continuous valid -> writes:
  - MemAddress 0x00400000, MemData 0x20080005;
  - MemAddress 0x00400004, MemData 0x3C011001;
  - each MemWrite one cycle wide, five cycles apart; then Done=1, CpuHold=0, WordsWritten=2.
- Same stream with ByteValid low for 7 cycles between bytes 2 and 3 -> identical writes and data; MemWrite delayed by exactly 7 cycles.
- Header 00 21 with MEMORY_DEPTH=32 -> Error=1, no MemWrite, ByteReady=0; subsequent Start plus a valid header loads correctly.
- Header 00 00 -> Done on the cycle after the 2nd header byte; zero writes.
- Header 00 20 followed by 32 words -> last write at 0x0040007C; Start pulse during load ignored; WordsWritten=32.
